// File: rtl/flash_loader_pkg.sv
// flash_loader_pkg: shared constants for the flash loader.
// State encoding, bus strobe values and default bus widths.
package flash_loader_pkg;

    localparam int unsigned ADDR_W_DEF  = 15;
    localparam int unsigned COUNT_W_DEF = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_RGAP  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [3:0] STRB_WRITE = 4'b1111;
    localparam logic [3:0] STRB_READ  = 4'b0000;

endpackage

// File: rtl/flash_loader_packer.sv
// byte_packer: assembles four accepted bytes into a little-endian 32-bit word.
// full_o flags the byte that completes the word; the word is held until
// the next byte is loaded.
module byte_packer
    import flash_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    output logic [1:0]  cnt_o,
    output logic [31:0] word_o,
    output logic        full_o
);

    logic [1:0]  cnt_q;
    logic [31:0] word_q;

    // Place each accepted byte into its lane and advance the byte count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else if (load_i) begin
            word_q[{cnt_q, 3'b000} +: 8] <= byte_i;
            cnt_q                        <= cnt_q + 2'd1;
        end
    end

    assign cnt_o  = cnt_q;
    assign word_o = word_q;
    assign full_o = load_i && (cnt_q == 2'd3);

endmodule

// File: rtl/flash_loader.sv
// flash_loader: streams bytes from a valid/ready source, packs them into
// 32-bit words and writes them to consecutive word addresses.
// Optional read-back verify is enabled by defining FLASH_LOADER_VERIFY_EN.
module flash_loader
    import flash_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [COUNT_W-1:0] word_count,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               mem_select,
    output logic [3:0]         mem_wstrb,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata,
    input  logic               mem_ready,
    output logic               busy,
    output logic               done,
    output logic               error
);

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] idx_q, idx_d;

    logic        accept_byte;
    logic        word_full;
    logic [31:0] packed_word;
    logic [1:0]  byte_cnt_unused;
    logic        last_word;

    assign byte_ready  = (state_q == S_FILL);
    assign accept_byte = byte_ready && byte_valid;
    assign last_word   = (idx_q == count_q - COUNT_W'(1));

    byte_packer u_packer (
        .clk    (clk),
        .reset  (reset),
        .load_i (accept_byte),
        .byte_i (byte_data),
        .cnt_o  (byte_cnt_unused),
        .word_o (packed_word),
        .full_o (word_full)
    );

    // Next-state logic: sequence each word through fill, write and recovery gaps.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        count_d = count_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    count_d = word_count;
                    idx_d   = '0;
                    state_d = (word_count == '0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (word_full) state_d = S_WRITE;
            end
            S_WRITE: begin
                if (mem_ready) state_d = S_GAP;
            end
`ifdef FLASH_LOADER_VERIFY_EN
            S_GAP: begin
                state_d = S_READ;
            end
            S_READ: begin
                if (mem_ready) state_d = S_RGAP;
            end
            S_RGAP: begin
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FILL;
                    idx_d   = idx_q + COUNT_W'(1);
                end
            end
`else
            S_GAP: begin
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_FILL;
                    idx_d   = idx_q + COUNT_W'(1);
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and load-context registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    // Bus outputs are decoded from state so they drop on the edge that samples mem_ready.
    always_comb begin
        mem_select = 1'b0;
        mem_wstrb  = STRB_READ;
        mem_wdata  = '0;
        mem_addr   = '0;
        if (state_q == S_WRITE) begin
            mem_select = 1'b1;
            mem_wstrb  = STRB_WRITE;
            mem_wdata  = packed_word;
            mem_addr   = base_q + ADDR_W'(idx_q);
        end
`ifdef FLASH_LOADER_VERIFY_EN
        if (state_q == S_READ) begin
            mem_select = 1'b1;
            mem_wstrb  = STRB_READ;
            mem_addr   = base_q + ADDR_W'(idx_q);
        end
`endif
    end

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done = (state_q == S_DONE);

`ifdef FLASH_LOADER_VERIFY_EN
    logic error_q;
    logic start_ok;

    assign start_ok = start && (state_q == S_IDLE);

    // Sticky read-back mismatch flag, cleared when a new load is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else if (start_ok) begin
            error_q <= 1'b0;
        end else if ((state_q == S_READ) && mem_ready && (mem_rdata != packed_word)) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    logic rdata_unused;

    assign rdata_unused = ^mem_rdata;
    assign error        = 1'b0;
`endif

endmodule

// File: doc/flash_loader.md
FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, meaning word-address width of the memory bus.
REQ-002 SHALL have parameter COUNT_W, default 16, meaning width of the word-count input.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, as listed in REQ-004 and REQ-005.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a load; ignored while busy.
REQ-007 base_addr  input  ADDR_W  first word address, sampled on accepted start.
REQ-008 word_count  input  COUNT_W  number of 32-bit words to load, sampled on accepted start.
REQ-009 byte_valid  input  1  source byte available.
REQ-010 byte_data  input  8  source byte.
REQ-011 byte_ready  output  1  byte accepted when byte_valid and byte_ready are both high.
REQ-012 mem_select  output  1  bus request to the memory responder.
REQ-013 mem_wstrb  output  4  byte write strobes; 4'b0000 means read.
REQ-014 mem_addr  output  ADDR_W  word address.
REQ-015 mem_wdata  output  32  write data.
REQ-016 mem_rdata  input  32  read data, valid when mem_ready is high.
REQ-017 mem_ready  input  1  responder completion; arrives one cycle after the select it answers.
REQ-018 busy  output  1  high from accepted start until done.
REQ-019 done  output  1  single-cycle pulse at the end of a load.
REQ-020 error  output  1  sticky verify-mismatch flag, cleared on accepted start.

Function
REQ-021 States SHALL be IDLE, FILL, WRITE, GAP, READ, RGAP and DONE; READ and RGAP are present only per REQ-033.
- IDLE -> FILL on start, or IDLE -> DONE on start when word_count == 0 (no bus activity).
REQ-022 FILL SHALL hold byte_ready high and accept 4 bytes little-endian: byte k goes to bits [8k+7:8k].
- Accepting the 4th byte moves to WRITE on the next edge.
- byte_ready SHALL be low in every other state.
REQ-023 WRITE SHALL drive mem_select=1, mem_wstrb=4'b1111, mem_addr = base_addr + word index (mod 2^ADDR_W), and mem_wdata = the packed word.
- These SHALL be held stable until mem_ready is sampled high.
- mem_select SHALL drop on that same edge.
REQ-024 GAP SHALL last exactly one cycle, with mem_select=0 and mem_ready ignored, to absorb the responder's trailing ready.
REQ-025 After GAP, the next state SHALL be FILL if words remain, otherwise DONE.
REQ-026 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-027 Address SHALL wrap silently from 2^ADDR_W-1 to 0.
REQ-028 With an immediately ready responder, each word SHALL occupy exactly 4 FILL cycles, 2 WRITE cycles and 1 GAP cycle.
REQ-029 start asserted while busy SHALL be ignored; start in the same cycle as DONE SHALL be ignored.
REQ-030 mem_wstrb and mem_wdata SHALL be 0 whenever mem_select is 0.

Reset
REQ-031 reset SHALL force the state to IDLE and clear the word index, byte count and packed word.
- Outputs: byte_ready, mem_select, mem_wstrb, mem_addr, mem_wdata, busy, done and error all go to 0.
REQ-032 reset asserted mid-load SHALL abandon the transfer with no further bus cycles and no done pulse.

Configuration
REQ-033 With macro FLASH_LOADER_VERIFY_EN defined, GAP SHALL go to READ instead of the REQ-025 transition.
- READ drives mem_select=1, mem_wstrb=0 and the same mem_addr until mem_ready.
- On mem_ready, mem_rdata is compared with the written word; a mismatch sets error.
- RGAP (one cycle, mem_ready ignored) then follows the REQ-025 transitions.
REQ-034 Without FLASH_LOADER_VERIFY_EN, READ and RGAP and the compare logic SHALL be absent, and error SHALL be constant 0.

Structure
REQ-035 Package flash_loader_pkg SHALL hold the state encoding, the read/write strobe constants and the default ADDR_W and COUNT_W.
REQ-036 Byte-to-word assembly SHALL be a sub-module byte_packer with a byte input, a 2-bit byte count, a word output and a full flag.

Verification
REQ-037 Load of 1 word at base 0x0010 with bytes 11,22,33,44 -> one write: addr 0x0010, wdata 0x44332211, wstrb 1111; done pulses once.
REQ-038 word_count=0 -> done pulses 1 cycle after start; mem_select never asserts.
REQ-039 Load of 2 words at base 0x7FFF -> writes to 0x7FFF then 0x0000.
REQ-040 Verify build with a responder corrupting bit 0 of word 1 (of 3) -> error=1 at the end, all 3 words written, and error cleared by the next start.
REQ-041 Reset pulsed during WRITE -> mem_select=0 immediately, no done pulse; a subsequent load succeeds.
REQ-042 start pulsed while busy and byte_valid throttled to 1 of 3 cycles -> second start ignored and all words packed correctly.
